// File: rtl/parking_meter_ctrl_if.sv
// Signal bundle between the parking meter controller and its environment.
// The master drives the coin/button/timer inputs; the controller is the slave.
interface parking_meter_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             s;
    logic             h;
    logic             d;
    logic             c;
    logic             t;
    logic             p;
    logic             ct;
    logic             rej;
    logic [CNT_W-1:0] L;
    logic [2:0]       state;

    modport master (
        output s, h, d, c, t,
        input  p, ct, rej, L, state
    );

    modport slave (
        input  s, h, d, c, t,
        output p, ct, rej, L, state
    );
endinterface

// File: rtl/parking_meter_ctrl.sv
// Parking meter controller: collects 50c/100c coins as timer credit, then runs
// one external timer cycle per credited unit, accepting top-up coins meanwhile.
module parking_meter_ctrl #(
    parameter int CNT_W      = 4,
    parameter int MAX_UNITS  = 15,
    parameter int HALF_VAL   = 1,
    parameter int DOLLAR_VAL = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    parking_meter_ctrl_if.slave bus
);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] HALF_EXT   = SUM_W'(HALF_VAL);
    localparam logic [SUM_W-1:0] DOLLAR_EXT = SUM_W'(DOLLAR_VAL);
    localparam logic [SUM_W-1:0] MAX_EXT    = SUM_W'(MAX_UNITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        ARM       = 3'd2,
        WAIT_RUN  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_next;
    logic [CNT_W-1:0] l_q;
    logic [CNT_W-1:0] l_next;
    logic             h_q;
    logic             d_q;
    logic             p_q;
    logic             ct_q;
    logic             rej_q;

    logic             h_edge;
    logic             d_edge;
    logic             coin_any;
    logic             accepting;
    logic             decrement;
    logic             fits;
    logic [SUM_W-1:0] coin_val;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] sum;

    // The credit check is made against the count after any same-cycle
    // decrement, so a top-up on the closing edge of a timer cycle can still fit.
    always_comb begin
        h_edge    = bus.h & ~h_q;
        d_edge    = bus.d & ~d_q;
        coin_any  = h_edge | d_edge;
        coin_val  = d_edge ? DOLLAR_EXT : HALF_EXT;
        accepting = ((state_q == COLLECT) && !bus.c) ||
                    (state_q == WAIT_RUN) || (state_q == WAIT_DONE);
        decrement = (state_q == WAIT_DONE) && bus.t && (l_q != '0);
        base      = {1'b0, l_q} - SUM_W'(decrement);
        sum       = base + coin_val;
        fits      = (sum <= MAX_EXT);
        l_next    = (accepting && coin_any && fits) ? sum[CNT_W-1:0] : base[CNT_W-1:0];
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:      if (bus.s) state_next = COLLECT;
            COLLECT: begin
                if (bus.c)       state_next = IDLE;
                else if (!bus.s) state_next = (l_next != '0) ? ARM : IDLE;
            end
            ARM:       state_next = WAIT_RUN;
            WAIT_RUN:  if (!bus.t) state_next = WAIT_DONE;
            WAIT_DONE: if (bus.t) state_next = (l_next == '0) ? IDLE : ARM;
            default:   state_next = IDLE;
        endcase
    end

    // p and ct are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            h_q     <= 1'b0;
            d_q     <= 1'b0;
            p_q     <= 1'b0;
            ct_q    <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            h_q     <= bus.h;
            d_q     <= bus.d;
            state_q <= state_next;
            p_q     <= (state_next == ARM) || (state_next == WAIT_RUN) ||
                       (state_next == WAIT_DONE);
            ct_q    <= (state_next == ARM);
            rej_q   <= accepting && coin_any && (!fits || (h_edge && d_edge));
            case (state_q)
                COLLECT:             l_q <= bus.c ? '0 : l_next;
                WAIT_RUN, WAIT_DONE: l_q <= l_next;
                ARM:                 l_q <= l_q;
                default:             l_q <= '0;
            endcase
        end
    end

    assign bus.state = state_q;
    assign bus.L     = l_q;
    assign bus.p     = p_q;
    assign bus.ct    = ct_q;
    assign bus.rej   = rej_q;
endmodule

// File: doc/parking_meter_ctrl.md
PARKING_METER_CTRL -- requirements
Module: parking_meter_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the credit counter L.
REQ-002 SHALL have parameter MAX_UNITS, default 15: maximum credit in timer units; must be at most 2^CNT_W-1.
REQ-003 SHALL have parameter HALF_VAL, default 1: timer units credited per 50c coin.
REQ-004 SHALL have parameter DOLLAR_VAL, default 2: timer units credited per 100c coin.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port s, input, 1 bit: Start, held high during coin insertion.
REQ-008 SHALL have port h, input, 1 bit: 50c coin sensor, level.
REQ-009 SHALL have port d, input, 1 bit: 100c coin sensor, level.
REQ-010 SHALL have port c, input, 1 bit: cancel request.
REQ-011 SHALL have port t, input, 1 bit: external timer status; idles high, low while a timer cycle runs.
REQ-012 SHALL have port p, output, 1 bit: parking paid/active.
REQ-013 SHALL have port ct, output, 1 bit: timer start pulse.
REQ-014 SHALL have port rej, output, 1 bit: coin-rejected pulse.
REQ-015 SHALL have port L, output, CNT_W bits: remaining credited units.
REQ-016 SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-017 SHALL register h and d, and SHALL count one coin per rising edge, i.e. input high while its previous-cycle register is low.
REQ-018 SHALL treat coin edges on h and d in the same cycle as a credit of the d coin, with a rej pulse for the h coin.
REQ-019 SHALL implement the states IDLE=0, COLLECT=1, ARM=2, WAIT_RUN=3, WAIT_DONE=4; codes 5-7 SHALL go to IDLE on the next clock.
REQ-020 IDLE: SHALL hold L=0 and ignore coins; s=1 SHALL move the FSM to COLLECT.
REQ-021 COLLECT: SHALL set L to L+val on each accepted coin edge.
REQ-022 COLLECT: when s=0, SHALL go to ARM if L>0 and to IDLE if L==0; s=0 takes effect on the same edge as a coin credit.
REQ-023 COLLECT: c=1 SHALL clear L to 0 and go to IDLE, with priority over coins and over s.
REQ-024 ARM: SHALL last exactly one cycle with ct=1, then go to WAIT_RUN.
REQ-025 WAIT_RUN: SHALL go to WAIT_DONE on t==0 and otherwise wait indefinitely.
REQ-026 WAIT_DONE: on t==1, SHALL decrement L; SHALL go to IDLE if the new L==0, else to ARM.
REQ-027 In WAIT_RUN and WAIT_DONE, SHALL accept coin edges as top-up credit regardless of s.
REQ-028 In WAIT_RUN and WAIT_DONE, SHALL ignore c.
REQ-029 When a decrement and a top-up occur in the same cycle, SHALL set the new L to L-1+val, evaluated against MAX_UNITS after the decrement.
REQ-030 SHALL reject any coin for which L+val > MAX_UNITS: L unchanged, rej=1 for exactly one cycle.
REQ-031 SHALL NOT let L exceed MAX_UNITS or underflow below 0.
REQ-032 SHALL drive p=1 exactly when state is ARM, WAIT_RUN or WAIT_DONE.
REQ-033 SHALL drive ct=1 only in ARM.
REQ-034 SHALL drive all outputs from registers or from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, L=0, p=0, ct=0, rej=0 and the coin-edge registers to 0, including mid-timer-cycle.
REQ-036 A coin input held high when rst_n releases SHALL count as one edge only if the FSM is in a coin-accepting state.

Verification
REQ-037 Single 50c: s=1, one h pulse, s=0 -> L=1, one ct pulse; t low 3 cycles then high -> L=0, IDLE, p=0.
REQ-038 100c+50c+100c: three coin pulses then s=0 -> L=5, exactly five ct pulses, each after t returns high; final IDLE with L=0.
REQ-039 Saturation: seven d pulses -> L=14; 8th d -> rej for one cycle, L=14; then h -> L=15.
REQ-040 Cancel: L=3 in COLLECT, c=1 -> next cycle IDLE, L=0, no ct.
REQ-041 Top-up: WAIT_DONE with L=1, h edge on the same cycle t rises -> L=1, state ARM, further ct pulse.
REQ-042 Reset mid-cycle: rst_n low during WAIT_RUN with L=4 -> immediately IDLE, L=0, p=0; s/h sequence after release works as in REQ-037.
